// File: rtl/blue_ctrl.sv
// Blue character motion controller: key-driven horizontal motion, a three-state
// jump trajectory, animation state, and the scan-to-sprite-ROM address path.
module blue_ctrl #(
  parameter int SPR_W    = 47,
  parameter int SPR_H    = 60,
  parameter int X_INIT   = 40,
  parameter int X_MAX    = 593,
  parameter int Y_GROUND = 400,
  parameter int STEP     = 2,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [2:0]  blue_state,
  output logic [13:0] blue,
  output logic        blue_in
);

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S = 11'(SPR_H);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} jump_st_e;

  jump_st_e    st_q, st_d;
  logic [4:0]  vy_q, vy_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        dir_q, dir_d;
  logic [2:0]  bs_q, bs_d;
  logic [13:0] blue_q, blue_d;
  logic        blue_in_q, blue_in_d;

  logic        rising;
  logic [4:0]  vy_eff;
  logic [10:0] y_sum;
  logic signed [10:0] dx, dy;

  function automatic logic [9:0] step_left(input logic [9:0] x);
    logic signed [10:0] t;
    t = $signed({1'b0, x}) - STEP_S;
    return t[10] ? 10'd0 : t[9:0];
  endfunction

  function automatic logic [9:0] step_right(input logic [9:0] x);
    logic [10:0] t;
    t = {1'b0, x} + 11'(STEP);
    return (t > 11'(X_MAX)) ? 10'(X_MAX) : t[9:0];
  endfunction

  function automatic logic [4:0] fall_speed(input logic [4:0] v);
    logic [5:0] t;
    t = {1'b0, v} + 6'(GRAVITY);
    return (t > 6'(V_MAX)) ? 5'(V_MAX) : t[4:0];
  endfunction

  always_comb begin
    st_d    = st_q;
    vy_d    = vy_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    bs_d    = bs_q;
    rising  = 1'b0;
    vy_eff  = vy_q;
    y_sum   = {1'b0, pos_y_q} + {6'd0, vy_q};
    if (frame_tick) begin
      // A launch tick already applies the first upward step.
      case (st_q)
        GROUND: begin
          if (key_jump) begin
            rising = 1'b1;
            vy_eff = 5'(JUMP_V0);
          end
        end
        RISE: rising = 1'b1;
        FALL: begin
          if (y_sum >= 11'(Y_GROUND)) begin
            pos_y_d = 10'(Y_GROUND);
            vy_d    = 5'd0;
            st_d    = GROUND;
          end else begin
            pos_y_d = y_sum[9:0];
            vy_d    = fall_speed(vy_q);
          end
        end
        default: st_d = GROUND;
      endcase
      if (rising) begin
        pos_y_d = pos_y_q - {5'd0, vy_eff};
        if (vy_eff <= 5'(GRAVITY)) begin
          vy_d = 5'd0;
          st_d = FALL;
        end else begin
          vy_d = vy_eff - 5'(GRAVITY);
          st_d = RISE;
        end
      end
      if (key_left && !key_right) begin
        pos_x_d = step_left(pos_x_q);
        dir_d   = 1'b0;
      end else if (key_right && !key_left) begin
        pos_x_d = step_right(pos_x_q);
        dir_d   = 1'b1;
      end
      if (st_d != GROUND)              bs_d = {2'b10, dir_d};
      else if (key_left ^ key_right)   bs_d = {2'b01, dir_d};
      else                             bs_d = {2'b00, dir_d};
    end
  end

  // Scan address path: runs every cycle against the current position registers.
  always_comb begin
    dx        = $signed({1'b0, pix_x}) - $signed({1'b0, pos_x_q});
    dy        = $signed({1'b0, pix_y}) - $signed({1'b0, pos_y_q});
    blue_in_d = !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);
    blue_d    = blue_in_d ? (14'(dy[9:0]) * 14'(SPR_W) + 14'(dx[9:0])) : 14'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= GROUND;
      vy_q      <= 5'd0;
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 10'(Y_GROUND);
      dir_q     <= 1'b1;
      bs_q      <= 3'b001;
      blue_q    <= 14'd0;
      blue_in_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      vy_q      <= vy_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_q     <= dir_d;
      bs_q      <= bs_d;
      blue_q    <= blue_d;
      blue_in_q <= blue_in_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign blue_state = bs_q;
  assign blue       = blue_q;
  assign blue_in    = blue_in_q;

endmodule

// File: tb/tb_blue_ctrl.sv
// Directed bench for blue_ctrl: motion, jump trajectory, clamping, reset and address path.
module tb_blue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic [9:0]  pix_x = 10'd0, pix_y = 10'd0;
  logic [9:0]  pos_x, pos_y;
  logic [2:0]  blue_state;
  logic [13:0] blue;
  logic        blue_in;

  int n_cmp = 0;
  int n_err = 0;

  blue_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .pix_x(pix_x), .pix_y(pix_y),
    .pos_x(pos_x), .pos_y(pos_y), .blue_state(blue_state),
    .blue(blue), .blue_in(blue_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic scan(input int x, input int y);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    reset_dut();
    chk("rst_pos_x", pos_x, 40);
    chk("rst_pos_y", pos_y, 400);
    chk("rst_state", blue_state, 3'b001);
    chk("rst_blue", blue, 0);
    chk("rst_blue_in", blue_in, 0);

    // Idle ticks
    ticks(3);
    chk("idle_pos_x", pos_x, 40);
    chk("idle_pos_y", pos_y, 400);
    chk("idle_state", blue_state, 3'b001);
    chk("idle_blue_in", blue_in, 0);

    // Address path
    scan(40, 400);
    chk("addr_org_blue", blue, 0);
    chk("addr_org_in", blue_in, 1);
    scan(86, 459);
    chk("addr_corner_blue", blue, 2819);
    chk("addr_corner_in", blue_in, 1);
    scan(87, 400);
    chk("addr_right_in", blue_in, 0);
    chk("addr_right_blue", blue, 0);
    scan(39, 400);
    chk("addr_left_in", blue_in, 0);
    chk("addr_left_blue", blue, 0);
    scan(40, 460);
    chk("addr_below_in", blue_in, 0);
    scan(0, 0);

    // Single-tick jump pulse
    key_jump = 1'b1;
    tick();
    key_jump = 1'b0;
    chk("jmp_t1_y", pos_y, 388);
    chk("jmp_t1_state", blue_state, 3'b101);
    ticks(11);
    chk("jmp_t12_y", pos_y, 322);
    chk("jmp_t12_state", blue_state, 3'b101);
    tick();
    chk("jmp_t13_y", pos_y, 322);
    ticks(11);
    chk("jmp_t24_y", pos_y, 388);
    chk("jmp_t24_state", blue_state, 3'b101);
    tick();
    chk("jmp_t25_y", pos_y, 400);
    chk("jmp_t25_state", blue_state, 3'b001);
    chk("jmp_x_hold", pos_x, 40);

    // Held jump relaunches after landing
    key_jump = 1'b1;
    ticks(25);
    chk("hold_t25_y", pos_y, 400);
    chk("hold_t25_state", blue_state, 3'b001);
    tick();
    chk("hold_t26_y", pos_y, 388);
    chk("hold_t26_state", blue_state, 3'b101);

    // Reset on RISE tick 5 beats a simultaneous frame_tick
    ticks(3);
    chk("rise_t4_y", pos_y, 400 - 12 - 11 - 10 - 9);
    key_right = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_tick = 1'b0;
    chk("rstj_y", pos_y, 400);
    chk("rstj_x", pos_x, 40);
    chk("rstj_state", blue_state, 3'b001);
    key_right = 1'b0;
    key_jump = 1'b0;
    tick();
    chk("rstj_ground_y", pos_y, 400);
    chk("rstj_ground_state", blue_state, 3'b001);

    // Left run with clamp at 0
    key_left = 1'b1;
    tick();
    chk("left_t1_state", blue_state, 3'b010);
    ticks(9);
    chk("left_t10_x", pos_x, 20);
    ticks(10);
    chk("left_t20_x", pos_x, 0);
    ticks(5);
    chk("left_t25_x", pos_x, 0);
    chk("left_t25_state", blue_state, 3'b010);
    key_left = 1'b0;
    tick();
    chk("left_rel_state", blue_state, 3'b000);

    // Both keys hold position and direction
    key_left = 1'b1;
    key_right = 1'b1;
    tick();
    chk("both_x", pos_x, 0);
    chk("both_state", blue_state, 3'b000);
    key_left = 1'b0;

    // Right run to 590, then right+jump clamps at X_MAX
    ticks(295);
    chk("right_x590", pos_x, 590);
    chk("right_state", blue_state, 3'b011);
    key_jump = 1'b1;
    tick();
    chk("rj_t1_x", pos_x, 592);
    chk("rj_t1_state", blue_state, 3'b101);
    tick();
    chk("rj_t2_x", pos_x, 593);
    tick();
    chk("rj_t3_x", pos_x, 593);
    chk("rj_t3_state", blue_state, 3'b101);
    key_jump = 1'b0;
    key_right = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
